// File: rtl/fix_acc.sv
// Sign-magnitude frame accumulator fed by fix_add: sums LEN samples into a wider
// saturating register and offers each frame total on a valid/ready output.
module fix_acc #(
  parameter int N   = 32,
  parameter int LEN = 4,
  parameter int EXT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [N+1:0]      in_sum,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N+1+EXT:0]  out_acc,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int AW = N + 1 + EXT;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state, state_nxt;
  logic            acc_sign;
  logic [AW-1:0]   acc_mag;
  logic [CW-1:0]   cnt;
  logic            sat;
  logic            accept, last;
  logic            in_sign;
  logic [AW-1:0]   in_mag;
  logic [AW+1:0]   sum_res;

  // Clamp an AW+1 bit magnitude to AW bits; returns {overflow, magnitude}.
  function automatic logic [AW:0] sat_clamp(input logic [AW:0] wide);
    if (wide[AW]) sat_clamp = {1'b1, {AW{1'b1}}};
    else          sat_clamp = {1'b0, wide[AW-1:0]};
  endfunction

  // Sign-magnitude add; returns {overflow, sign, magnitude}, never negative zero.
  function automatic logic [AW+1:0] sm_add(input logic a_s, input logic [AW-1:0] a_m,
                                           input logic b_s, input logic [AW-1:0] b_m);
    logic [AW:0]   clamped;
    logic          s;
    logic [AW-1:0] m;
    logic          ovf;
    ovf = 1'b0;
    if (a_s == b_s) begin
      clamped = sat_clamp({1'b0, a_m} + {1'b0, b_m});
      ovf     = clamped[AW];
      m       = clamped[AW-1:0];
      s       = a_s;
    end else if (a_m > b_m) begin
      m = a_m - b_m;
      s = a_s;
    end else begin
      m = b_m - a_m;
      s = b_s;
    end
    if (m == '0) s = 1'b0;
    sm_add = {ovf, s, m};
  endfunction

  assign in_mag   = {{EXT{1'b0}}, in_sum[N:0]};
  assign in_sign  = in_sum[N+1] && (in_sum[N:0] != '0);
  assign sum_res  = sm_add(acc_sign, acc_mag, in_sign, in_mag);
  assign in_ready = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CW'(LEN - 1));

  always_comb begin
    state_nxt = state;
    if (clear)                             state_nxt = ACCUM;
    else if (state == ACCUM && accept && last) state_nxt = HOLD;
    else if (state == HOLD && out_ready)   state_nxt = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Accumulator, frame counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      out_acc  <= '0;
      out_sat  <= 1'b0;
    end else if (clear) begin
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
    end else if (accept) begin
      if (last) begin
        out_acc  <= sum_res[AW:0];
        out_sat  <= sat | sum_res[AW+1];
        acc_sign <= 1'b0;
        acc_mag  <= '0;
        cnt      <= '0;
        sat      <= 1'b0;
      end else begin
        acc_sign <= sum_res[AW];
        acc_mag  <= sum_res[AW-1:0];
        cnt      <= cnt + CW'(1);
        sat      <= sat | sum_res[AW+1];
      end
    end
  end
endmodule

// File: tb/tb_fix_acc.sv
// Bench for fix_acc: a default instance and an EXT=1 instance share stimulus and are
// checked every cycle against an integer-arithmetic frame model plus a vector table.
module tb_fix_acc;
  localparam int N   = 32;
  localparam int LEN = 4;
  localparam int AWA = N + 1 + 4;
  localparam int AWB = N + 1 + 1;

  logic           clk = 1'b0;
  logic           rst, clear, in_valid, out_ready;
  logic [N+1:0]   in_sum;
  logic           in_ready_a, out_valid_a, out_sat_a;
  logic [AWA:0]   out_acc_a;
  logic           in_ready_b, out_valid_b, out_sat_b;
  logic [AWB:0]   out_acc_b;

  fix_acc #(.N(N), .LEN(LEN), .EXT(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_acc(out_acc_a), .out_sat(out_sat_a),
    .out_valid(out_valid_a), .out_ready(out_ready));

  fix_acc #(.N(N), .LEN(LEN), .EXT(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_acc(out_acc_b), .out_sat(out_sat_b),
    .out_valid(out_valid_b), .out_ready(out_ready));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame model: signed integer accumulator clamped to +/-(2^AW-1)
  longint m_acc[2], m_oacc[2], m_max[2];
  int     m_cnt[2];
  bit     m_hold[2], m_sat[2], m_osat[2];

  typedef struct packed {
    logic [3:0]      sg;
    logic [3:0][N:0] mg;
    logic            es;
    longint          ma;
    longint          mb;
    logic            sa;
    logic            sb;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N+1:0] mk(input logic sg, input logic [N:0] mg);
    return {sg, mg};
  endfunction

  function automatic logic [63:0] enc(input longint v, input int aw);
    logic [63:0] mag;
    mag = (v < 0) ? 64'(-v) : 64'(v);
    return ((v < 0) ? (64'd1 << aw) : 64'd0) | mag;
  endfunction

  task automatic model_edge(input bit r, input bit c, input bit v, input logic [N+1:0] s,
                            input bit ordy);
    longint val, t;
    val = s[N+1] ? -longint'(s[N:0]) : longint'(s[N:0]);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_hold[i] = 0; m_oacc[i] = 0; m_osat[i] = 0;
      end else if (c) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_hold[i] = 0;
      end else if (m_hold[i]) begin
        if (ordy) m_hold[i] = 0;
      end else if (v) begin
        t = m_acc[i] + val;
        if (t > m_max[i])  begin t = m_max[i];  m_sat[i] = 1; end
        if (t < -m_max[i]) begin t = -m_max[i]; m_sat[i] = 1; end
        m_cnt[i]++;
        if (m_cnt[i] == LEN) begin
          m_oacc[i] = t; m_osat[i] = m_sat[i];
          m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_hold[i] = 1;
        end else begin
          m_acc[i] = t;
        end
      end
    end
  endtask

  task automatic compare();
    chk("in_ready_a",  64'(in_ready_a),  64'(!rst && !m_hold[0]));
    chk("out_valid_a", 64'(out_valid_a), 64'(m_hold[0]));
    chk("out_sat_a",   64'(out_sat_a),   64'(m_osat[0]));
    chk("out_acc_a",   64'(out_acc_a),   enc(m_oacc[0], AWA));
    chk("in_ready_b",  64'(in_ready_b),  64'(!rst && !m_hold[1]));
    chk("out_valid_b", 64'(out_valid_b), 64'(m_hold[1]));
    chk("out_sat_b",   64'(out_sat_b),   64'(m_osat[1]));
    chk("out_acc_b",   64'(out_acc_b),   enc(m_oacc[1], AWB));
  endtask

  // Drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic step(input bit v, input logic [N+1:0] s, input bit ordy, input bit c);
    in_valid = v; in_sum = s; out_ready = ordy; clear = c;
    @(posedge clk);
    model_edge(rst, c, v, s, ordy);
    @(negedge clk);
    compare();
  endtask

  task automatic frame4(input logic [N+1:0] s0, input logic [N+1:0] s1,
                        input logic [N+1:0] s2, input logic [N+1:0] s3);
    step(1, s0, 0, 0); step(1, s1, 0, 0); step(1, s2, 0, 0); step(1, s3, 0, 0);
  endtask

  initial begin
    m_max[0] = (64'sd1 <<< AWA) - 1;
    m_max[1] = (64'sd1 <<< AWB) - 1;
    tbl[0] = '{sg: 4'b0000, mg: {33'd4, 33'd3, 33'd2, 33'd1}, es: 0, ma: 10, mb: 10, sa: 0, sb: 0};
    tbl[1] = '{sg: 4'b1010, mg: {33'd0, 33'd1, 33'd8, 33'd5}, es: 1, ma: 2, mb: 2, sa: 0, sb: 0};
    tbl[2] = '{sg: 4'b0000, mg: {33'd0, 33'd0, 33'd0, 33'd2}, es: 0, ma: 2, mb: 2, sa: 0, sb: 0};
    tbl[3] = '{sg: 4'b0010, mg: {33'd0, 33'd0, 33'd7, 33'd7}, es: 0, ma: 0, mb: 0, sa: 0, sb: 0};
    tbl[4] = '{sg: 4'b1011, mg: {33'd0, 33'd2, 33'd4, 33'd3}, es: 1, ma: 5, mb: 5, sa: 0, sb: 0};
    tbl[5] = '{sg: 4'b0000, mg: {4{33'h1_FFFF_FFFF}}, es: 0,
               ma: 64'd34359738364, mb: 64'd17179869183, sa: 0, sb: 1};
    tbl[6] = '{sg: 4'b0010, mg: {33'd0, 33'd0, 33'd1, 33'd1}, es: 0, ma: 0, mb: 0, sa: 0, sb: 0};

    rst = 1; clear = 0; in_valid = 0; out_ready = 0; in_sum = '0;
    @(negedge clk);
    step(1, mk(0, 33'd5), 0, 0);
    step(0, '0, 0, 0);
    rst = 0;
    step(0, '0, 0, 0);

    // Vector table: one frame per row, one stalled cycle in HOLD, then handshake
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < LEN; j++) step(1, mk(tbl[i].sg[j], tbl[i].mg[j]), 0, 0);
      chk("tbl_valid_a", 64'(out_valid_a), 64'd1);
      chk("tbl_sign_a",  64'(out_acc_a[AWA]), 64'(tbl[i].es));
      chk("tbl_mag_a",   64'(out_acc_a[AWA-1:0]), tbl[i].ma);
      chk("tbl_sat_a",   64'(out_sat_a), 64'(tbl[i].sa));
      chk("tbl_sign_b",  64'(out_acc_b[AWB]), 64'(tbl[i].es));
      chk("tbl_mag_b",   64'(out_acc_b[AWB-1:0]), tbl[i].mb);
      chk("tbl_sat_b",   64'(out_sat_b), 64'(tbl[i].sb));
      step(1, mk(0, 33'd9), 0, 0);
      step(0, '0, 1, 0);
    end

    // Cancellation leaves a +0 accumulator mid-frame
    step(1, mk(0, 33'd3), 0, 0);
    step(1, mk(1, 33'd3), 0, 0);
    chk("acc_sign_zero", 64'(dut_a.acc_sign), 64'd0);
    chk("acc_mag_zero",  64'(dut_a.acc_mag), 64'd0);
    step(1, mk(0, 33'd0), 0, 0);
    step(1, mk(0, 33'd0), 0, 0);
    step(0, '0, 1, 0);

    // Backpressure: three stalled cycles with in_valid high consume nothing
    frame4(mk(0, 33'd1), mk(0, 33'd1), mk(0, 33'd1), mk(0, 33'd1));
    for (int k = 0; k < 3; k++) step(1, mk(0, 33'd50), 0, 0);
    chk("bp_hold_mag", 64'(out_acc_a), 64'd4);
    step(1, mk(0, 33'd50), 1, 0);
    chk("bp_ready_back", 64'(in_ready_a), 64'd1);
    frame4(mk(0, 33'd2), mk(0, 33'd2), mk(0, 33'd2), mk(0, 33'd2));
    chk("bp_next_frame", 64'(out_acc_a), 64'd8);
    step(0, '0, 1, 0);

    // Random traffic with gaps, backpressure and occasional clears
    for (int k = 0; k < 300; k++) begin
      logic [N:0] mg;
      mg = ($urandom_range(0, 3) == 0) ? {1'($urandom_range(0, 1)), 32'($urandom())}
                                       : 33'($urandom_range(0, 100));
      step($urandom_range(0, 2) != 0, mk(1'($urandom_range(0, 1)), mg),
           $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
    end
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    // Clear after two samples discards them and the sample in the clear cycle
    step(1, mk(0, 33'd9), 0, 0);
    step(1, mk(0, 33'd9), 0, 0);
    step(1, mk(0, 33'd9), 0, 1);
    frame4(mk(0, 33'd1), mk(0, 33'd1), mk(0, 33'd1), mk(0, 33'd1));
    chk("clear_mag", 64'(out_acc_a), 64'd4);

    // Clear in HOLD drops the pending result
    step(0, '0, 0, 1);
    chk("clear_hold_valid", 64'(out_valid_a), 64'd0);

    // Reset in HOLD
    frame4(mk(1, 33'd6), mk(0, 33'd1), mk(0, 33'd1), mk(0, 33'd1));
    rst = 1;
    step(0, '0, 0, 0);
    chk("rst_valid", 64'(out_valid_a), 64'd0);
    chk("rst_acc",   64'(out_acc_a), 64'd0);
    chk("rst_sat",   64'(out_sat_b), 64'd0);
    rst = 0;
    step(0, '0, 0, 0);
    chk("rst_ready", 64'(in_ready_a), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
